// File: rtl/image_uart_tx_pkg.sv
// Shared types and UART frame constants for the image transmitter.
// IMTX_PARITY_EN selects 8E1 framing instead of 8N1.
package imtx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_SEND,
    S_NEXT,
    S_DONE
  } imtx_state_e;

  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS_NOPAR     = DATA_BITS + 2;
  localparam int FRAME_BITS_PAR       = DATA_BITS + 3;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

`ifdef IMTX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PAR;
`else
  localparam int FRAME_BITS = FRAME_BITS_NOPAR;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/image_uart_tx_if.sv
// BRAM read port between the image transmitter (master) and the processed-image BRAM (slave).
interface image_uart_tx_if #(
  parameter int ADDR_W = 14
);
  logic              ena_tx;
  logic              wea_tx;
  logic [ADDR_W-1:0] addr_tx;
  logic [7:0]        dout_tx;

  modport master (output ena_tx, output wea_tx, output addr_tx, input dout_tx);
  modport slave  (input ena_tx, input wea_tx, input addr_tx, output dout_tx);
endinterface

// File: rtl/image_uart_tx_serializer.sv
// UART frame serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Parity is compiled in only when IMTX_PARITY_EN is defined.
module uart_tx_serializer
  import imtx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       done_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int SW = FRAME_BITS - 1;

  logic [CW-1:0] baud_q, baud_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SW-1:0] sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          active_q, active_d;
  logic [SW-1:0] payload;

`ifdef IMTX_PARITY_EN
  assign payload = {1'b1, even_parity(data_i), data_i};
`else
  assign payload = {1'b1, data_i};
`endif

  // done marks the final cycle of the stop bit so the caller can overlap its next step
  assign done_o = active_q && (baud_q == '0) && (bit_q == '0);
  assign tx_o   = tx_q;

  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    active_d = active_q;
    if (load_i) begin
      active_d = 1'b1;
      tx_d     = 1'b0;
      baud_d   = CW'(CLKS_PER_BIT - 1);
      bit_d    = BW'(FRAME_BITS - 1);
      sh_d     = payload;
    end else if (active_q) begin
      if (baud_q == '0) begin
        if (bit_q == '0) begin
          active_d = 1'b0;
        end else begin
          tx_d   = sh_q[0];
          sh_d   = {1'b1, sh_q[SW-1:1]};
          bit_d  = bit_q - BW'(1);
          baud_d = CW'(CLKS_PER_BIT - 1);
        end
      end else begin
        baud_d = baud_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/image_uart_tx.sv
// Streams PIXELS bytes from the processed-image BRAM over UART in ascending address order.
// Framing is 8N1 by default, 8E1 when IMTX_PARITY_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | BRAM enable pulse at addr_tx
//   WAIT  | absorb RD_LATENCY cycles of read latency
//   LOAD  | hand the byte to the serializer
//   SEND  | frame in flight
//   NEXT  | advance address or finish
//   DONE  | image sent; wait for start to fall
module image_uart_tx
  import imtx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PIXELS       = 16384,
  parameter int ADDR_W       = 14,
  parameter int RD_LATENCY   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  image_uart_tx_if.master   bram,
  output logic              TxD,
  output logic              busy,
  output logic              ImTxComplete
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  imtx_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        wait_q, wait_d;
  logic              ena;
  logic              ser_load;
  logic              ser_done;

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .reset (reset),
    .load_i(ser_load),
    .data_i(bram.dout_tx),
    .done_o(ser_done),
    .tx_o  (TxD)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
    ena      = 1'b0;
    ser_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ena     = 1'b1;
        wait_d  = 2'(RD_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) state_d = S_LOAD;
        else              wait_d  = wait_q - 2'd1;
      end
      S_LOAD: begin
        ser_load = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (ser_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        // full-width compare: with PIXELS = 2**ADDR_W this stops at all-ones, never wraps
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (!start) begin
          addr_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
    end
  end

  assign bram.ena_tx  = ena;
  assign bram.wea_tx  = 1'b0;
  assign bram.addr_tx = addr_q;

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign ImTxComplete = (state_q == S_DONE);

endmodule

// File: tb/tb_image_uart_tx.sv
// Scoreboarded bench for image_uart_tx: expected bytes are queued at start, a UART monitor decodes TxD.
module tb_image_uart_tx;
  import imtx_pkg::*;

  localparam int CPB = 4;
  localparam int PIX = 4;
  localparam int AW  = 2;
  localparam int FB  = FRAME_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic tx1, busy1, done1, tx2, busy2, done2;

  image_uart_tx_if #(.ADDR_W(AW)) bif1 ();
  image_uart_tx_if #(.ADDR_W(AW)) bif2 ();

  always #5 clk = ~clk;

  image_uart_tx #(.CLKS_PER_BIT(CPB), .PIXELS(PIX), .ADDR_W(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .bram(bif1),
    .TxD(tx1), .busy(busy1), .ImTxComplete(done1));

  image_uart_tx #(.CLKS_PER_BIT(CPB), .PIXELS(PIX), .ADDR_W(AW), .RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(rst_n), .start(start2), .bram(bif2),
    .TxD(tx2), .busy(busy2), .ImTxComplete(done2));

  logic [7:0] mem [PIX];
  logic [7:0] stage2;

  always @(posedge clk) if (bif1.ena_tx) bif1.dout_tx <= mem[bif1.addr_tx];
  always @(posedge clk) begin
    if (bif2.ena_tx) stage2 <= mem[bif2.addr_tx];
    bif2.dout_tx <= stage2;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] exp_q[$];

  task automatic push_image(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
    exp_q.push_back(b0); exp_q.push_back(b1);
    exp_q.push_back(b2); exp_q.push_back(b3);
  endtask

  // UART monitor / scoreboard
  int          frames = 0;
  int          nstarts = 0;
  bit          in_frame = 0;
  bit          gap_valid = 0;
  bit          stable;
  int          idle_cnt = 0;
  int          bit_idx;
  int          cnt;
  logic [FB-1:0] rx;

  always @(negedge clk) begin : monitor
    logic [7:0]    e;
    logic [FB-1:0] ef;
    if (!rst_n) begin
      in_frame  = 0;
      gap_valid = 0;
    end else if (!in_frame) begin
      if (tx1 === 1'b0) begin
        if (gap_valid) check("frame_gap", 32'(idle_cnt), 32'd4);
        nstarts++;
        in_frame = 1;
        bit_idx  = 0;
        cnt      = 1;
        rx       = '0;
        stable   = 1;
      end else begin
        idle_cnt++;
        if (!busy1) gap_valid = 0;
      end
    end else begin
      if (cnt < CPB) begin
        if (tx1 !== rx[bit_idx]) stable = 0;
        cnt++;
      end else begin
        bit_idx++;
        rx[bit_idx] = tx1;
        cnt = 1;
      end
      if (cnt == CPB && bit_idx == FB - 1) begin
        frames++;
        in_frame  = 0;
        gap_valid = 1;
        idle_cnt  = 0;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got frame 0x%0h expected none", rx);
        end else begin
          e  = exp_q.pop_front();
          ef = '0;
          for (int i = 0; i < 8; i++) ef[1+i] = e[i];
`ifdef IMTX_PARITY_EN
          ef[9] = ^e;
          if (e == 8'hA3) check("parity_a3", 32'(rx[9]), 32'd0);
          if (e == 8'h01) check("parity_01", 32'(rx[9]), 32'd1);
`endif
          ef[FB-1] = 1'b1;
          check("frame_bits", 32'(rx), 32'(ef));
          check("bit_width", 32'(stable), 32'd1);
        end
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done1 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 32'(done1), 32'd1);
  endtask

  initial begin : stim
    int base;
    int n;
    mem[0] = 8'h55; mem[1] = 8'hA3; mem[2] = 8'h00; mem[3] = 8'hFF;

    repeat (3) @(negedge clk);
    check("rst_txd", 32'(tx1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_ena", 32'(bif1.ena_tx), 32'd0);
    check("rst_wea", 32'(bif1.wea_tx), 32'd0);
    check("rst_addr", 32'(bif1.addr_tx), 32'd0);
    check("rst_txd2", 32'(tx2), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // latency: start sampled at the next rising edge k
    push_image(8'h55, 8'hA3, 8'h00, 8'hFF);
    start = 1'b1; start2 = 1'b1;
    @(negedge clk);
    check("lat_ena", 32'(bif1.ena_tx), 32'd1);
    check("lat_addr", 32'(bif1.addr_tx), 32'd0);
    check("lat_ena2", 32'(bif2.ena_tx), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("lat_tx_load", 32'(tx1), 32'd1);
    check("lat_ena_off", 32'(bif1.ena_tx), 32'd0);
    @(negedge clk);
    check("lat_tx_start", 32'(tx1), 32'd0);
    check("lat2_tx_load", 32'(tx2), 32'd1);
    @(negedge clk);
    check("lat2_tx_start", 32'(tx2), 32'd0);
    start2 = 1'b0;

    // basic stream with start held high
    wait_done("basic_done", 1000);
    check("basic_frames", 32'(frames), 32'd4);
    check("basic_queue", 32'(exp_q.size()), 32'd0);
    check("basic_busy", 32'(busy1), 32'd0);
    check("addr_last", 32'(bif1.addr_tx), 32'd3);

    // start still high: no retransmission
    repeat (100) @(negedge clk);
    check("hold_frames", 32'(frames), 32'd4);
    check("hold_done", 32'(done1), 32'd1);

    // retrigger with a different image
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done", 32'(done1), 32'd0);
    check("idle_addr", 32'(bif1.addr_tx), 32'd0);
    push_image(8'h01, 8'hA3, 8'h7F, 8'h80);
    start = 1'b1;
    wait_done("retrig_done", 1000);
    check("retrig_frames", 32'(frames), 32'd8);
    check("retrig_queue", 32'(exp_q.size()), 32'd0);

    // reset during data bit 3 of 0xA3
    start = 1'b0;
    repeat (2) @(negedge clk);
    push_image(8'h55, 8'hA3, 8'h00, 8'hFF);
    base = nstarts;
    start = 1'b1;
    n = 0;
    while (nstarts < base + 2 && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    check("second_frame_seen", 32'(nstarts), 32'(base + 2));
    repeat (4 * CPB) @(negedge clk);
    #1;
    check("tx_bit3_of_a3", 32'(tx1), 32'd0);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("mid_rst_txd", 32'(tx1), 32'd1);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_done", 32'(done1), 32'd0);
    check("mid_rst_addr", 32'(bif1.addr_tx), 32'd0);
    check("mid_rst_ena", 32'(bif1.ena_tx), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_image(8'h55, 8'hA3, 8'h00, 8'hFF);
    start = 1'b1;
    wait_done("after_rst_done", 1000);
    check("after_rst_frames", 32'(frames), 32'd13);
    check("after_rst_queue", 32'(exp_q.size()), 32'd0);
    start = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
